// File: rtl/text_sched_pkg.sv
// text_sched_pkg: shared state encoding, character codes and cursor helpers for the text buffer scheduler.
package text_sched_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, ROWCLR} state_t;
  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 60;
  localparam int CELLS = COLS_DEF * ROWS_DEF;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_BS = 8'h08;
  function automatic int next_row_start(input int cur, input int col, input int cols, input int cells);
    return (cur - col + cols >= cells) ? 0 : cur - col + cols;
  endfunction
endpackage

// File: rtl/text_cursor_ctr.sv
// text_cursor_ctr: cursor register with increment/wrap, saturating decrement, next-row and zero controls.
// Ports: clk, rst (async, active-high); inc, dec, nrow, zero move controls (zero has priority);
//        cursor = current cell address; at_col0 = this cycle's inc/CR move leaves the cursor on column 0.
module text_cursor_ctr
  import text_sched_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int COLS = COLS_DEF,
  parameter int N_CELLS = CELLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              nrow,
  input  logic              zero,
  output logic [ADDR_W-1:0] cursor,
  output logic              at_col0
);
  logic [ADDR_W-1:0] col;
  logic wrap, eol;
  always_comb begin
    wrap = cursor == ADDR_W'(N_CELLS - 1);
    eol = col == ADDR_W'(COLS - 1);
    at_col0 = nrow | (inc & (eol | wrap));
  end
  // col tracks the column alongside the address so no divider is needed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cursor <= '0;
      col <= '0;
    end else if (zero) begin
      cursor <= '0;
      col <= '0;
    end else if (nrow) begin
      cursor <= ADDR_W'(next_row_start(int'(cursor), int'(col), COLS, N_CELLS));
      col <= '0;
    end else if (inc) begin
      cursor <= wrap ? '0 : cursor + 1'b1;
      col <= (eol | wrap) ? '0 : col + 1'b1;
    end else if (dec && cursor != '0) begin
      cursor <= cursor - 1'b1;
      col <= (col == '0) ? ADDR_W'(COLS - 1) : col - 1'b1;
    end
endmodule

// File: rtl/text_buffer_scheduler.sv
// text_buffer_scheduler: arbitrates the single-port character RAM between display fetch, clear sweeps and keyboard writes.
// Ports: iCLK, iRST (async, active-high); iDISP_REQ/iDISP_ADDR -> oDISP_VALID/oDISP_DATA (1-cycle fetch);
//        iKEY_VALID/iKEY_CHAR/oKEY_READY keyboard handshake; iCLEAR full-screen clear; oBUSY sweep active;
//        oCURSOR cursor cell; oRAM_ADDR/oRAM_WE/oRAM_WDATA/iRAM_RDATA synchronous RAM port.
// Build option: define TEXT_SCHED_ROWCLR_EN to blank each new row when the cursor reaches its column 0.
module text_buffer_scheduler
  import text_sched_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int ADDR_W = 13,
  parameter int CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK_CHAR = 8'h20
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDISP_REQ,
  input  logic [ADDR_W-1:0] iDISP_ADDR,
  output logic              oDISP_VALID,
  output logic [CHAR_W-1:0] oDISP_DATA,
  input  logic              iKEY_VALID,
  input  logic [CHAR_W-1:0] iKEY_CHAR,
  output logic              oKEY_READY,
  input  logic              iCLEAR,
  output logic              oBUSY,
  output logic [ADDR_W-1:0] oCURSOR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic              oRAM_WE,
  output logic [CHAR_W-1:0] oRAM_WDATA,
  input  logic [CHAR_W-1:0] iRAM_RDATA
);
`ifdef TEXT_SCHED_ROWCLR_EN
  localparam bit ROWCLR_EN = 1'b1;
`else
  localparam bit ROWCLR_EN = 1'b0;
`endif
  localparam int N_CELLS = COLS * ROWS;
  state_t state, nxt;
  logic pending, disp_v, land0, sweeping, last, xfer, is_cr, is_bs, inc, dec, nrow, zero, wr_key, we;
  logic [ADDR_W-1:0] sweep, cursor, sweep_a, key_a;
  text_cursor_ctr #(.ADDR_W(ADDR_W), .COLS(COLS), .N_CELLS(N_CELLS)) u_cursor (
    .clk(iCLK), .rst(iRST), .inc(inc), .dec(dec), .nrow(nrow), .zero(zero),
    .cursor(cursor), .at_col0(land0)
  );
  // sweep is the offset within the current sweep; it only advances on cycles the display leaves free
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      state <= IDLE;
      pending <= 1'b0;
      sweep <= '0;
      disp_v <= 1'b0;
    end else begin
      state <= nxt;
      disp_v <= iDISP_REQ;
      pending <= zero ? 1'b0 : (iCLEAR && state != CLEAR) ? 1'b1 : pending;
      sweep <= !sweeping ? '0 : iDISP_REQ ? sweep : last ? '0 : sweep + 1'b1;
    end
  always_comb begin
    sweeping = state != IDLE;
    last = (state == ROWCLR) ? sweep == ADDR_W'(COLS - 1) : sweep == ADDR_W'(N_CELLS - 1);
    nxt = (state == IDLE) ? ((ROWCLR_EN && land0) ? ROWCLR : pending ? CLEAR : IDLE)
        : (!iDISP_REQ && last) ? IDLE : state;
  end
  always_comb begin
    oKEY_READY = state == IDLE && !pending && !iDISP_REQ && !iRST;
    xfer = iKEY_VALID & oKEY_READY;
    is_cr = iKEY_CHAR == CHAR_W'(CHAR_CR);
    is_bs = iKEY_CHAR == CHAR_W'(CHAR_BS);
    inc = xfer & ~is_cr & ~is_bs;
    nrow = xfer & is_cr;
    dec = xfer & is_bs;
    zero = state == CLEAR && !iDISP_REQ && last;
    wr_key = xfer & ~is_cr;
    sweep_a = (state == ROWCLR) ? cursor + sweep : sweep;
    key_a = is_bs ? ((cursor == '0) ? '0 : cursor - 1'b1) : cursor;
    we = !iRST && !iDISP_REQ && (sweeping || wr_key);
    oRAM_WE = we;
    oRAM_ADDR = iRST ? '0 : iDISP_REQ ? iDISP_ADDR : sweeping ? sweep_a : wr_key ? key_a : '0;
    oRAM_WDATA = we ? ((sweeping || is_bs) ? BLANK_CHAR : iKEY_CHAR) : '0;
    oBUSY = sweeping;
    oCURSOR = cursor;
    oDISP_VALID = disp_v;
    oDISP_DATA = disp_v ? iRAM_RDATA : '0;
  end
endmodule

// File: tb/tb_text_buffer_scheduler.sv
// tb_text_buffer_scheduler: directed self-checking bench for text_buffer_scheduler with a behavioural RAM.
module tb_text_buffer_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic disp_req = 1'b0;
  logic [12:0] disp_addr = '0;
  logic disp_valid;
  logic [7:0] disp_data;
  logic key_valid = 1'b0;
  logic [7:0] key_char = '0;
  logic key_ready;
  logic clear = 1'b0;
  logic busy;
  logic [12:0] cursor, ram_addr;
  logic ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic [7:0] mem [0:8191];
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  logic last_we, last_rdy;
  logic [12:0] last_addr;
  logic [7:0] last_data;

  text_buffer_scheduler dut (
    .iCLK(clk), .iRST(rst), .iDISP_REQ(disp_req), .iDISP_ADDR(disp_addr),
    .oDISP_VALID(disp_valid), .oDISP_DATA(disp_data), .iKEY_VALID(key_valid),
    .iKEY_CHAR(key_char), .oKEY_READY(key_ready), .iCLEAR(clear), .oBUSY(busy),
    .oCURSOR(cursor), .oRAM_ADDR(ram_addr), .oRAM_WE(ram_we), .oRAM_WDATA(ram_wdata),
    .iRAM_RDATA(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_key(input logic [7:0] c);
    int n = 0;
    while (!key_ready && n < 300) begin
      tick;
      n++;
    end
    if (!key_ready) timeouts++;
    key_valid = 1'b1;
    key_char = c;
    #1;
    last_rdy = key_ready;
    last_we = ram_we;
    last_addr = ram_addr;
    last_data = ram_wdata;
    tick;
    key_valid = 1'b0;
  endtask

  initial begin
    int bad, exp_a, stalls, busy_cyc, i, snap;
    tick;
    tick;
    check("rst_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_cursor", cursor, 0);
    check("rst_ready", key_ready, 0);
    check("rst_disp_valid", disp_valid, 0);
    rst = 1'b0;
    #1;
    check("idle_ready", key_ready, 1);

    send_key(8'h41);
    check("keyA_we", last_we, 1);
    check("keyA_addr", last_addr, 0);
    check("keyA_data", last_data, 8'h41);
    check("keyA_cursor", cursor, 1);
    check("keyA_ready_next", key_ready, 1);
    check("keyA_mem", mem[0], 8'h41);

    for (int k = 0; k < 5; k++) send_key(8'h42 + 8'(k));
    check("type_cursor", cursor, 6);

    disp_req = 1'b1;
    disp_addr = 13'd5;
    key_valid = 1'b1;
    key_char = 8'h5A;
    #1;
    check("disp_ready_low", key_ready, 0);
    check("disp_no_we", ram_we, 0);
    check("disp_addr", ram_addr, 5);
    tick;
    disp_req = 1'b0;
    key_valid = 1'b0;
    #1;
    check("disp_valid", disp_valid, 1);
    check("disp_data", disp_data, 8'h46);
    check("disp_cursor_kept", cursor, 6);
    tick;
    check("disp_valid_drop", disp_valid, 0);

    clear = 1'b1;
    tick;
    clear = 1'b0;
    #1;
    check("clr_pending_ready", key_ready, 0);
    check("clr_busy_pre", busy, 0);
    tick;
    check("clr_busy", busy, 1);
    bad = 0; exp_a = 0; stalls = 0; busy_cyc = 0; i = 0;
    while (busy && i < 10000) begin
      disp_req = (i % 3 == 2);
      disp_addr = 13'd7;
      #1;
      busy_cyc++;
      if (disp_req) begin
        stalls++;
        if (ram_we) bad++;
      end else begin
        if (!(ram_we && ram_addr == 13'(exp_a) && ram_wdata == 8'h20)) bad++;
        exp_a++;
      end
      tick;
      i++;
    end
    disp_req = 1'b0;
    #1;
    check("clr_order", bad, 0);
    check("clr_cells", exp_a, 4800);
    check("clr_busy_cycles", busy_cyc, 4800 + stalls);
    check("clr_busy_end", busy, 0);
    check("clr_cursor", cursor, 0);
    check("clr_ready", key_ready, 1);
    bad = 0;
    for (int a = 0; a < 4800; a++) if (mem[a] !== 8'h20) bad++;
    check("clr_mem_blank", bad, 0);

    send_key(8'h08);
    check("bs0_we", last_we, 1);
    check("bs0_addr", last_addr, 0);
    check("bs0_data", last_data, 8'h20);
    check("bs0_cursor", cursor, 0);

    for (int k = 0; k < 85; k++) send_key(8'h78);
    check("cur85", cursor, 85);
    send_key(8'h0D);
    check("cr_ready", last_rdy, 1);
    check("cr_no_we", last_we, 0);
    check("cr_cursor", cursor, 160);
    send_key(8'h08);
    check("bs_addr", last_addr, 159);
    check("bs_data", last_data, 8'h20);
    check("bs_cursor", cursor, 159);
    send_key(8'h79);
    check("refill_cursor", cursor, 160);

    for (int k = 0; k < 4639; k++) send_key(8'h79);
    check("cur4799", cursor, 4799);
    send_key(8'h42);
    check("wrap_we", last_we, 1);
    check("wrap_addr", last_addr, 4799);
    check("wrap_data", last_data, 8'h42);
    check("wrap_cursor", cursor, 0);
`ifdef TEXT_SCHED_ROWCLR_EN
    check("rowclr_busy", busy, 1);
    check("rowclr_ready", key_ready, 0);
    bad = 0; exp_a = 0; i = 0;
    while (busy && i < 200) begin
      if (!(ram_we && ram_addr == 13'(exp_a) && ram_wdata == 8'h20)) bad++;
      exp_a++;
      tick;
      i++;
    end
    check("rowclr_cycles", exp_a, 80);
    check("rowclr_order", bad, 0);
`else
    check("norowclr_busy", busy, 0);
`endif
    check("wrap_ready", key_ready, 1);

    send_key(8'h51);
    check("pre_rst_cursor", cursor, 1);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    i = 0;
    while (!(ram_we && ram_addr == 13'd1000) && i < 3000) begin
      tick;
      i++;
    end
    check("sweep_at_1000", ram_addr, 1000);
    rst = 1'b1;
    #1;
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_addr", ram_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cursor", cursor, 0);
    check("mid_rst_ready", key_ready, 0);
    tick;
    tick;
    rst = 1'b0;
    snap = wr_cnt;
    for (int k = 0; k < 20; k++) tick;
    check("post_rst_writes", wr_cnt - snap, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", key_ready, 1);
    check("key_timeouts", timeouts, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
